uart_rx: RTL and testbench

- 8N1 UART receiver; the downstream stage of hello_world. Consumes its serial tx line and rebuilds bytes for bench loopback checking and future on-chip command input.
- Samples each bit at its midpoint using a per-bit clock counter.
- Presents each received byte with a one-cycle valid strobe and flags framing errors.

---
 rtl/uart_rx.sv | 179 +++++++++++++++++
 tb/tb_uart_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with midpoint sampling; `UART_RX_PARITY_EN selects 8E1 framing.
module uart_rx #(
    parameter int CLOCK_RATE     = 10,
    parameter int BAUD_RATE      = 1,
    parameter int CLOCKS_PER_BIT = CLOCK_RATE / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_error,
    output logic       parity_error,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta, rx_s, rx_s_prev;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             tick;
    logic             fall;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    // Synchroniser and edge-detect flops reset high so reset itself never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_s_prev <= 1'b1;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_s_prev <= rx_s;
        end
    end

    assign fall = rx_s_prev & ~rx_s;
    assign tick = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? cnt_q : cnt_q - CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // Counter is loaded so it reaches zero at the middle of the start bit.
                if (fall) begin
                    state_d = S_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            S_START: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_d   = S_DATA;
                        cnt_d     = FULL_LOAD;
                        bit_idx_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    cnt_d     = FULL_LOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    par_d   = rx_s;
                    cnt_d   = FULL_LOAD;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    data_d = shift_q;
                    if (!rx_s) begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end else begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_q != ^shift_q) perr_d = 1'b1;
                        else                   valid_d = 1'b1;
`else
                        valid_d = 1'b1;
`endif
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data          = data_q;
    assign valid         = valid_q;
    assign framing_error = ferr_q;
    assign busy          = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error  = perr_q;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx.
module tb_uart_rx;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       parity_error;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx #(.CLOCK_RATE(10), .BAUD_RATE(1)) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .data(data),
        .valid(valid),
        .framing_error(framing_error),
        .parity_error(parity_error),
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frame_start_cyc = 0;

    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    int         last_valid_cyc = -1;
    logic [7:0] rx_bytes[$];
    logic       busy_after_valid = 1'b1;
    int         busy_run = 0;
    int         busy_max = 0;
    logic       valid_q = 1'b0;
    logic       ferr_q = 1'b0;
    logic       perr_q = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            rx_bytes.push_back(data);
            last_valid_cyc = cyc;
        end
        if (framing_error) ferr_cnt++;
        if (parity_error) perr_cnt++;
        if (valid || framing_error || parity_error) begin
            checks++;
            if ((int'(valid) + int'(framing_error) + int'(parity_error)) > 1 ||
                (valid && valid_q) || (framing_error && ferr_q) || (parity_error && perr_q)) begin
                errors++;
                $display("FAIL strobe_exclusive cyc=%0d got v=%b fe=%b pe=%b (prev %b%b%b) want single one-cycle strobe",
                         cyc, valid, framing_error, parity_error, valid_q, ferr_q, perr_q);
            end
        end
        if (valid_q) busy_after_valid = busy;
        busy_run = busy ? busy_run + 1 : 0;
        if (busy_run > busy_max) busy_max = busy_run;
        valid_q = valid;
        ferr_q  = framing_error;
        perr_q  = parity_error;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        frame_start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_flip);
`endif
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        wait_cycles(3);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", framing_error); end
        checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", parity_error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        wait_cycles(5);
    endtask

    task automatic test_single_byte;
        int v0;
        int f0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1);
        wait_cycles(3);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL single_valid_count got %0d want 1", valid_cnt - v0); end
        checks++; if (data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", data); end
        checks++; if (last_valid_cyc !== frame_start_cyc + 98) begin
            errors++; $display("FAIL single_latency got %0d want %0d", last_valid_cyc, frame_start_cyc + 98);
        end
        checks++; if (busy_after_valid !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b want 0", busy_after_valid); end
        checks++; if (ferr_cnt !== f0) begin errors++; $display("FAIL single_ferr got %0d want %0d", ferr_cnt, f0); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] msg[5];
        int base;
        int f0;
        msg  = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        base = rx_bytes.size();
        f0   = ferr_cnt;
        for (int i = 0; i < 5; i++) send_frame(msg[i], 1'b1);
        wait_cycles(5);
        checks++; if (rx_bytes.size() - base !== 5) begin
            errors++; $display("FAIL loop_count got %0d want 5", rx_bytes.size() - base);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_bytes.size() <= base + i || rx_bytes[base + i] !== msg[i]) begin
                errors++;
                $display("FAIL loop_byte%0d got %h want %h", i,
                         (rx_bytes.size() > base + i) ? rx_bytes[base + i] : 8'hxx, msg[i]);
            end
        end
        checks++; if (ferr_cnt !== f0) begin errors++; $display("FAIL loop_ferr got %0d want %0d", ferr_cnt, f0); end
    endtask

    task automatic test_glitch;
        int v0;
        int f0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        busy_max = 0;
        rx = 1'b0;
        wait_cycles(3);
        rx = 1'b1;
        wait_cycles(30);
        checks++; if (busy_max < 1 || busy_max > 6) begin errors++; $display("FAIL glitch_busy_len got %0d want 1..6", busy_max); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b want 0", busy); end
        checks++; if (valid_cnt !== v0 || ferr_cnt !== f0) begin
            errors++; $display("FAIL glitch_strobe got v=%0d f=%0d want v=%0d f=%0d", valid_cnt, ferr_cnt, v0, f0);
        end
    endtask

    task automatic test_framing_error;
        int v0;
        int f0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        wait_cycles(50);
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", ferr_cnt - f0); end
        checks++; if (data !== 8'h3C) begin errors++; $display("FAIL ferr_data got %h want 3c", data); end
        checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL ferr_valid got %0d want %0d", valid_cnt, v0); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low got %b want 1", busy); end
        rx = 1'b1;
        wait_cycles(10);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release got %b want 0", busy); end
        send_frame(8'h81, 1'b1);
        wait_cycles(3);
        checks++; if (valid_cnt - v0 !== 1 || data !== 8'h81) begin
            errors++; $display("FAIL ferr_next_frame got n=%0d data=%h want n=1 data=81", valid_cnt - v0, data);
        end
        checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_single got %0d want 1", ferr_cnt - f0); end
    endtask

    task automatic test_reset_midframe;
        int v0;
        int f0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        wait_cycles(CPB);
        rx = 1'b1;
        wait_cycles(4 * CPB + 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || valid !== 1'b0 || framing_error !== 1'b0 || data !== 8'h00) begin
            errors++; $display("FAIL rstmid_outputs got busy=%b v=%b fe=%b data=%h want 0 0 0 00",
                               busy, valid, framing_error, data);
        end
        wait_cycles(60);
        checks++; if (valid_cnt !== v0 || ferr_cnt !== f0) begin
            errors++; $display("FAIL rstmid_strobe got v=%0d f=%0d want v=%0d f=%0d", valid_cnt, ferr_cnt, v0, f0);
        end
        send_frame(8'h12, 1'b1);
        wait_cycles(3);
        checks++; if (valid_cnt - v0 !== 1 || data !== 8'h12) begin
            errors++; $display("FAIL rstmid_next got n=%0d data=%h want n=1 data=12", valid_cnt - v0, data);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int v0;
        int p0;
        v0 = valid_cnt;
        p0 = perr_cnt;
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        wait_cycles(3);
        checks++; if (valid_cnt - v0 !== 1 || data !== 8'h07) begin
            errors++; $display("FAIL parity_good got n=%0d data=%h want n=1 data=07", valid_cnt - v0, data);
        end
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        wait_cycles(3);
        checks++; if (perr_cnt - p0 !== 1) begin errors++; $display("FAIL parity_err_count got %0d want 1", perr_cnt - p0); end
        checks++; if (valid_cnt - v0 !== 1 || data !== 8'h07) begin
            errors++; $display("FAIL parity_bad got n=%0d data=%h want n=1 data=07", valid_cnt - v0, data);
        end
    endtask
`else
    task automatic test_parity;
        checks++; if (perr_cnt !== 0) begin errors++; $display("FAIL parity_tied got %0d want 0", perr_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_midframe();
        test_parity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
